store_narrow_16: RTL

- Store-side narrowing unit for the MIPS datapath; it performs the inverse of immediate/load zero-extension.
- Takes a 32-bit store operand (SB/SH/SW) with its byte address from the MEM stage.
- Extracts the low 8/16/32 bits and issues them to a 16-bit-wide data memory with byte enables.
- Splits word stores into two halfword beats; valid/ready on both sides.

---
 rtl/store_narrow_16_pkg.sv | 19 +
 rtl/store_narrow_16_lane_sel.sv | 44 ++++
 rtl/store_narrow_16.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/store_narrow_16_pkg.sv
// Shared size codes, FSM states and byte-enable patterns for the store
// narrowing unit.
package store_narrow_16_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] BE_LO  = 2'b01;
  localparam logic [1:0] BE_HI  = 2'b10;
  localparam logic [1:0] BE_ALL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10
  } state_e;

endpackage

// File: rtl/store_narrow_16_lane_sel.sv
// Combinational lane mapping: picks the 16-bit write data and byte enables
// for a beat, and flags size/alignment combinations that cannot be issued.
module store_lane_sel
  import store_narrow_16_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  input  logic        beat_i,
  output logic [15:0] data_o,
  output logic [1:0]  be_o,
  output logic        legal_o
);

  // Lane steering per store size; bytes are replicated on both lanes.
  always_comb begin
    data_o  = 16'h0000;
    be_o    = 2'b00;
    legal_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        data_o  = {data_i[7:0], data_i[7:0]};
        be_o    = addr_lo_i[0] ? BE_HI : BE_LO;
        legal_o = 1'b1;
      end
      SZ_HALF: begin
        data_o  = data_i[15:0];
        be_o    = BE_ALL;
        legal_o = ~addr_lo_i[0];
      end
      SZ_WORD: begin
        data_o  = beat_i ? data_i[31:16] : data_i[15:0];
        be_o    = BE_ALL;
        legal_o = (addr_lo_i == 2'b00);
      end
      default: begin
        data_o  = 16'h0000;
        be_o    = 2'b00;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_16.sv
// Store narrowing unit: accepts SB/SH/SW requests and issues one or two
// halfword beats to a 16-bit data memory with byte enables.
module store_narrow_16
  import store_narrow_16_pkg::*;
#(
  parameter int ADDR_W = 32
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       entrada,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       salida,
  output logic [1:0]        mem_be,
  output logic              done,
  output logic              misalign
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = {{(ADDR_W-2){1'b0}}, 2'b10};

  state_e            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       data_q, data_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       salida_q, salida_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;

  logic              sel_beat;
  logic [1:0]        sel_size;
  logic [1:0]        sel_addr_lo;
  logic [31:0]       sel_data;
  logic [15:0]       lane_data;
  logic [1:0]        lane_be;
  logic              lane_legal;

  // In IDLE the lane mapper looks at the incoming request; while BEAT0 is
  // outstanding it prepares the upper half from the captured operand.
  assign sel_beat    = (state_q == ST_BEAT0);
  assign sel_size    = sel_beat ? size_q : req_size;
  assign sel_addr_lo = sel_beat ? mem_addr_q[1:0] : req_addr[1:0];
  assign sel_data    = sel_beat ? data_q : entrada;

  store_lane_sel u_lane_sel (
    .size_i    (sel_size),
    .addr_lo_i (sel_addr_lo),
    .data_i    (sel_data),
    .beat_i    (sel_beat),
    .data_o    (lane_data),
    .be_o      (lane_be),
    .legal_o   (lane_legal)
  );

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    data_d      = data_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    salida_d    = salida_q;
    mem_be_d    = mem_be_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (lane_legal) begin
            state_d     = ST_BEAT0;
            size_d      = req_size;
            data_d      = entrada;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr[ADDR_W-1:1], 1'b0};
            salida_d    = lane_data;
            mem_be_d    = lane_be;
          end else begin
            misalign_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BEAT0: begin
        if (mem_ready) begin
          if (size_q == SZ_WORD) begin
            state_d    = ST_BEAT1;
            mem_addr_d = mem_addr_q + ADDR_STEP;
            salida_d   = lane_data;
            mem_be_d   = lane_be;
          end else begin
            state_d     = ST_IDLE;
            mem_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end else begin
          state_d = ST_BEAT0;
        end
      end
      ST_BEAT1: begin
        if (mem_ready) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
        end else begin
          state_d = ST_BEAT1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      size_q      <= 2'b00;
      data_q      <= 32'h0000_0000;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      salida_q    <= 16'h0000;
      mem_be_q    <= 2'b00;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      data_q      <= data_d;
      req_ready_q <= req_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      salida_q    <= salida_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign salida    = salida_q;
  assign mem_be    = mem_be_q;
  assign done      = done_q;
  assign misalign  = misalign_q;

endmodule
